// File: rtl/voice_pkg.sv
// Shared constants for the voice oscillator: waveform codes, LFSR setup and
// the default noise sample divider.
package voice_pkg;

  typedef enum logic [2:0] {
    WF_SAW      = 3'd0,
    WF_SQUARE   = 3'd1,
    WF_TRIANGLE = 3'd2,
    WF_SINE     = 3'd3,
    WF_RAMP     = 3'd4,
    WF_SAW_TRI  = 3'd5,
    WF_NOISE    = 3'd6,
    WF_UNDEF    = 3'd7
  } wave_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int NOISE_DIV_DEFAULT = 3125;

endpackage

// File: rtl/voice_osc_sine_rom.sv
// Full-cycle sine table, unsigned, centred on M/2, one-cycle synchronous read.
// Table contents are elaboration-time constants derived from OUT_W.
module sine_rom #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic [OUT_W-1:0] address,
  output logic [OUT_W-1:0] q
);

  localparam int  DEPTH = 2 ** OUT_W;
  localparam real PI    = 3.14159265358979323846;

  // Halves round up: floor(x + 0.5) on a non-negative value.
  function automatic logic [OUT_W-1:0] entry(input int k);
    real x;
    x = (real'(DEPTH - 1) / 2.0) * (1.0 + $sin(2.0 * PI * real'(k) / real'(DEPTH)));
    return OUT_W'($rtoi(x + 0.5));
  endfunction

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    assign rom[g] = entry(g);
  end

  always_ff @(posedge clk) begin
    q <= rom[address];
  end

endmodule

// File: rtl/voice_osc.sv
// Single-voice DDS oscillator: glide on the increment, gate-synced phase,
// eight waveforms through a two-stage output pipeline, and an LFSR noise source.
module voice_osc
  import voice_pkg::*;
#(
  parameter int PHASE_W   = 32,
  parameter int OUT_W     = 8,
  parameter int NOISE_DIV = NOISE_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gate,
  input  logic [PHASE_W-1:0] inc,
  input  logic [3:0]         glide,
  input  logic [OUT_W-1:0]   pw,
  input  logic               sync_en,
  input  logic [2:0]         wave_form,
  output logic [OUT_W-1:0]   signal_out,
  output logic               wrap
);

  localparam logic [OUT_W-1:0] M     = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] H     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] H_M1  = H - OUT_W'(1);
  localparam int               DIV_W = $clog2(NOISE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(NOISE_DIV - 1);

  logic [PHASE_W-1:0]        cur_inc;
  logic [PHASE_W-1:0]        phase;
  logic                      gate_q;
  logic                      sync_q;
  logic signed [PHASE_W:0]   d;
  logic signed [PHASE_W:0]   step_sh;
  logic [PHASE_W-1:0]        step;
  logic [PHASE_W:0]          sum;

  logic [15:0]               lfsr;
  logic                      fb;
  logic [DIV_W-1:0]          div;
  logic [OUT_W-1:0]          noise_reg;

  logic [OUT_W-1:0]          s;
  logic [OUT_W-1:0]          s1;
  wave_t                     wf1;
  logic [OUT_W-1:0]          pw1;
  logic [OUT_W-1:0]          noise1;
  logic [OUT_W-1:0]          rom_q;
  logic [OUT_W-1:0]          tri_v;
  logic [OUT_W-1:0]          wave_val;

  // Signed distance to the target; a shift that underflows to zero still
  // moves by one LSB so cur_inc lands on inc exactly.
  always_comb begin
    d       = {1'b0, inc} - {1'b0, cur_inc};
    step_sh = d >>> glide;
    step    = step_sh[PHASE_W-1:0];
    if (step_sh == '0 && d != '0) begin
      step = d[PHASE_W] ? {PHASE_W{1'b1}} : PHASE_W'(1);
    end
  end

  assign sum = {1'b0, phase} + {1'b0, cur_inc};
  assign fb  = ^(lfsr & LFSR_TAPS);
  assign s   = phase[PHASE_W-1 -: OUT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_inc   <= '0;
      phase     <= '0;
      wrap      <= 1'b0;
      gate_q    <= 1'b0;
      sync_q    <= 1'b0;
      lfsr      <= LFSR_SEED;
      div       <= '0;
      noise_reg <= '0;
    end else begin
      gate_q  <= gate;
      sync_q  <= sync_en & gate & ~gate_q;
      cur_inc <= (glide == 4'd0) ? inc : cur_inc + step;
      // A pending sync overrides any carry from this cycle's addition.
      if (sync_q) begin
        phase <= '0;
        wrap  <= 1'b0;
      end else begin
        phase <= sum[PHASE_W-1:0];
        wrap  <= sum[PHASE_W];
      end
      lfsr <= {lfsr[14:0], fb};
      if (div == DIV_LAST) begin
        div       <= '0;
        noise_reg <= lfsr[15 -: OUT_W];
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  sine_rom #(.OUT_W(OUT_W)) u_sine_rom (
    .clk     (clk),
    .address (s),
    .q       (rom_q)
  );

  // Stage 1 aligns every waveform's inputs with the registered ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      wf1    <= WF_SAW;
      pw1    <= '0;
      noise1 <= '0;
    end else begin
      s1     <= s;
      wf1    <= wave_t'(wave_form);
      pw1    <= (pw == '0) ? H : pw;
      noise1 <= noise_reg;
    end
  end

  always_comb begin
    tri_v    = {s1[OUT_W-2:0], 1'b0};
    wave_val = H_M1;
    case (wf1)
      WF_SAW:      wave_val = s1;
      WF_SQUARE:   wave_val = (s1 < pw1) ? M : '0;
      WF_TRIANGLE: wave_val = s1[OUT_W-1] ? M - tri_v : tri_v;
      WF_SINE:     wave_val = rom_q;
      WF_RAMP:     wave_val = M - s1;
      WF_SAW_TRI:  wave_val = s1[OUT_W-1] ? M - s1 : s1 + H_M1;
      WF_NOISE:    wave_val = noise1;
      WF_UNDEF:    wave_val = H_M1;
      default:     wave_val = H_M1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      signal_out <= '0;
    end else begin
      signal_out <= wave_val;
    end
  end

endmodule

// File: doc/voice_osc.md
# voice_osc

Parametrised single-voice oscillator core, successor to the fixed 8-bit voice generator. It takes a DDS phase increment from the note/pitch translator and produces one of eight waveforms at configurable output width. Over the fixed block it adds:
- pulse-width-modulated square
- portamento (glide) on the increment
- gate-triggered phase sync
- a phase-wrap strobe
- a programmable noise sample rate

It sits between the note translator and the voice mixer; one instance per voice.

## Interface
Parameters:
- PHASE_W, 32, phase accumulator width (16..32)
- OUT_W, 8, output sample width (4..16)
- NOISE_DIV, 3125, clk cycles per noise sample (≥2; 3125 = 16 kHz at 50 MHz)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- gate  in  1  note gate, synchronous to clk
- inc  in  PHASE_W  target phase increment per clk
- glide  in  4  portamento shift; 0 = off
- pw  in  OUT_W  square threshold; 0 means half-scale
- sync_en  in  1  enable phase reset on gate rise
- wave_form  in  3  waveform select; codes are in the package
- signal_out  out  OUT_W  unsigned sample, registered
- wrap  out  1  one-cycle pulse on phase-accumulator overflow

## Operation
- Notation: M = 2^OUT_W−1; H = 2^(OUT_W−1); s = phase[PHASE_W−1 -: OUT_W].
- Increment register cur_inc:
  - glide=0: cur_inc ← inc.
  - Otherwise d = inc−cur_inc (signed, PHASE_W+1 bits) and step = d>>>glide (arithmetic shift).
  - If step=0 and d≠0, step = sign(d)·1. cur_inc ← cur_inc+step.
  - cur_inc therefore always reaches inc exactly.
- Phase: phase ← phase+cur_inc mod 2^PHASE_W. wrap=1 in the cycle after an addition that carries out.
- Gate edge: gate_q is registered; rise = gate & ~gate_q.
  - If rise & sync_en: phase ← 0 and wrap ← 0. Sync wins over carry.
  - Gate fall has no effect.
  - glide state is unaffected by gate.
- Waveforms (code: output):
  - SAW 000: s
  - SQUARE 001: (s < pw_eff) ? M : 0, where pw_eff = pw, or H when pw=0
  - TRIANGLE 010: t = s[OUT_W−2:0]<<1; MSB(s)=0 → t, else M−t
  - SINE 011: sine ROM[s]
  - RAMP 100: M−s
  - SAW_TRI 101: MSB(s)=1 → M−s, else s+H−1
  - NOISE 110: noise_reg
  - UNDEF 111: H−1
- Noise:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. Shifts every clk.
  - Divider counts 0..NOISE_DIV−1. At terminal count, noise_reg ← lfsr[15 -: OUT_W] and the counter returns to 0.
- wave_form and pw are sampled in pipeline stage 1, same cycle as the ROM address. A mode change takes effect with the same 2-cycle latency as phase.

## Timing
- Pipeline:
  - Stage 1 registers s, wave_form and pw_eff, and issues the ROM address.
  - Stage 2 registers signal_out.
  - signal_out at cycle t reflects phase at t−2 for every waveform. Sine is not allowed to lead or lag the others.
- inc to phase: cur_inc updates the cycle after inc changes, and phase uses it one cycle later.
- Sync: gate rises at cycle n → gate_q at n+1 → phase=0 at n+2 → signal_out shows s=0 at n+4.
- wrap is asserted in the same cycle the wrapped phase value is visible in the phase register.
- Reset values:
  - phase, cur_inc, gate_q, pipeline registers, signal_out, wrap, noise_reg: 0
  - divider: 0
  - lfsr: 16'hACE1
- Reset asserted mid-operation clears all state on the next edge. Reset has priority over sync, glide and noise update.
- No handshake. Output is valid every cycle after the first two post-reset cycles; it is 0 before that.

## Structure
- Shared package voice_pkg holds:
  - waveform codes (SAW..UNDEF)
  - LFSR seed and tap constants
  - default NOISE_DIV
- Sub-module sine_rom:
  - Parameter OUT_W. Ports clk, address[OUT_W−1:0], q[OUT_W−1:0]; 1-cycle synchronous read.
  - Entry k = round((M/2)·(1+sin(2πk/2^OUT_W))), with halves rounding up. For OUT_W=8: entry 0 = 128, entry 64 = 255, entry 192 = 0.
- The rest is one module: glide, accumulator, edge detect, noise, waveform mux and output register.

## Test plan
- Reset, PHASE_W=32, OUT_W=8, glide=0, inc=32'h0100_0000, SAW: after reset release, signal_out = 0,0, then increments by 1 per clk from 1; wrap pulses every 256 cycles, with exactly one cycle high.
- SQUARE with pw=64, same inc: signal_out=255 for 64 of every 256 cycles. With pw=0, it is 255 for 128 cycles.
- glide=4, cur_inc=0, inc steps to 32'h0001_0000: cur_inc rises monotonically, the first step is 32'h1000, and it equals 32'h0001_0000 exactly within 200 cycles with no overshoot.
- sync_en=1, phase mid-cycle, gate 0→1 at cycle n: phase=0 at n+2 and wrap stays 0. With sync_en=0, phase is unaffected.
- SINE vs SAW: toggle wave_form on a frozen phase (inc=0, s=64). Outputs are 255 and 64 respectively, each appearing 2 cycles after its select.
- NOISE with NOISE_DIV=4: noise_reg updates every 4 cycles and its values match a reference LFSR model from seed ACE1. Asserting rst mid-run restores the seed and zeros all outputs next cycle.
